// File: rtl/s2p_window.sv
// Serial-to-parallel sliding-window buffer: collects samples into an N-wide window
// and emits it every STRIDE samples, with ready/valid handshakes on both sides.
module s2p_window #(
   parameter int unsigned DATA_WIDTH   = 12,
   parameter int unsigned NUM_ELEMENTS = 5,
   parameter int unsigned STRIDE       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  s2p_ready_in,
   input  logic                  s2p_valid_in,
   input  logic [DATA_WIDTH-1:0] s2p_serial_in,
   input  logic                  s2p_last_in,
   input  logic                  s2p_ready_out,
   output logic                  s2p_valid_out,
   output logic [DATA_WIDTH-1:0] s2p_parallel_out [0:NUM_ELEMENTS-1],
   output logic                  s2p_last_out
);

   localparam int unsigned FW = $clog2(NUM_ELEMENTS + 1);
   localparam int unsigned SW = $clog2(STRIDE) + 1;

   typedef enum logic {FILL, STREAM} state_t;

   state_t                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_win       [0:NUM_ELEMENTS-1];
   logic [DATA_WIDTH-1:0] w_win_shift [0:NUM_ELEMENTS-1];
   logic [FW-1:0]         r_fill;
   logic [SW-1:0]         r_stride;
   logic                  w_acc;
   logic                  w_emit;
   logic                  w_stride_wrap;

   assign s2p_ready_in  = !s2p_valid_out || s2p_ready_out;
   assign w_acc         = s2p_valid_in && s2p_ready_in;
   assign w_stride_wrap = (r_stride == SW'(STRIDE - 1));

   always_comb begin
      for (int unsigned i = 0; i < NUM_ELEMENTS - 1; i++)
         w_win_shift[i] = r_win[i+1];
      w_win_shift[NUM_ELEMENTS-1] = s2p_serial_in;
   end

   always_comb begin
      w_emit      = 1'b0;
      w_state_nxt = r_state;
      if (w_acc) begin
         case (r_state)
            FILL: begin
               if (r_fill == FW'(NUM_ELEMENTS - 1)) begin
                  w_emit      = 1'b1;
                  w_state_nxt = STREAM;
               end
            end
            STREAM: begin
               if (w_stride_wrap)
                  w_emit = 1'b1;
            end
            default: w_state_nxt = FILL;
         endcase
         // last closes the frame after any emit on the same beat
         if (s2p_last_in)
            w_state_nxt = FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= FILL;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++)
            r_win[i] <= '0;
         r_fill   <= '0;
         r_stride <= '0;
      end else if (w_acc) begin
         if (s2p_last_in) begin
            for (int unsigned i = 0; i < NUM_ELEMENTS; i++)
               r_win[i] <= '0;
            r_fill   <= '0;
            r_stride <= '0;
         end else begin
            for (int unsigned i = 0; i < NUM_ELEMENTS; i++)
               r_win[i] <= w_win_shift[i];
            if (r_fill != FW'(NUM_ELEMENTS))
               r_fill <= r_fill + 1'b1;
            if (r_state == FILL || w_stride_wrap)
               r_stride <= '0;
            else
               r_stride <= r_stride + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++)
            s2p_parallel_out[i] <= '0;
         s2p_valid_out <= 1'b0;
         s2p_last_out  <= 1'b0;
      end else if (w_emit) begin
         for (int unsigned i = 0; i < NUM_ELEMENTS; i++)
            s2p_parallel_out[i] <= w_win_shift[i];
         s2p_valid_out <= 1'b1;
         s2p_last_out  <= s2p_last_in;
      end else if (s2p_ready_out) begin
         s2p_valid_out <= 1'b0;
      end
   end

endmodule
